// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide sequencer: the ALUCtrl
// encodings that select mult/div and the sequencer state type.
package mips_pkg;

    localparam logic [3:0] ALUCTRL_MULT = 4'b1111;
    localparam logic [3:0] ALUCTRL_DIV  = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add on the {carry, upper, lower} product register.
// Divide:   restoring step on {remainder (upper), quotient (lower)}.
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_upper,
    input  logic [WIDTH-1:0] i_lower,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_upper,
    output logic [WIDTH-1:0] o_lower
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH-1:0] w_trial;
    logic             w_borrow;

    // Compute both candidate next states and pick by mode.
    always_comb begin
        // Multiply: conditional add keeps its carry in bit WIDTH, then
        // the whole register shifts right so the carry lands in upper.
        w_sum = {1'b0, i_upper} + (i_lower[0] ? {1'b0, i_operand} : '0);

        // Divide: shift {rem, quot} left and try subtracting the divisor.
        // The remainder stays below the divisor, so when there is no
        // borrow the difference fits in WIDTH bits.
        w_shift_rem = {i_upper, i_lower[WIDTH-1]};
        w_borrow    = (w_shift_rem < {1'b0, i_operand});
        w_trial     = w_shift_rem[WIDTH-1:0] - i_operand;

        if (i_is_div) begin
            o_upper = w_borrow ? w_shift_rem[WIDTH-1:0] : w_trial;
            o_lower = {i_lower[WIDTH-2:0], ~w_borrow};
        end else begin
            o_upper = w_sum[WIDTH:1];
            o_lower = {w_sum[0], i_lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle mult/div sequencer owning the HI/LO registers. Busy stalls
// the pipeline while an operation iterates; done pulses for one cycle
// when HI/LO take the new result.
module hilo_muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    muldiv_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_next_upper;
    logic [WIDTH-1:0] w_next_lower;
    logic             w_is_div;

    assign w_is_div = (r_state == DIV);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div  (w_is_div),
        .i_upper   (r_upper),
        .i_lower   (r_lower),
        .i_operand (r_operand),
        .o_upper   (w_next_upper),
        .o_lower   (w_next_lower)
    );

    // Sequencer FSM with registered status outputs and HI/LO update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_upper   <= '0;
            r_lower   <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && alu_ctrl == ALUCTRL_MULT) begin
                        // Multiplier sits in lower; multiplicand is added.
                        r_upper   <= '0;
                        r_lower   <= operand_b;
                        r_operand <= operand_a;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_dbz     <= 1'b0;
                        r_state   <= MUL;
                    end else if (start && alu_ctrl == ALUCTRL_DIV) begin
                        if (operand_b == '0) begin
                            // Divide by zero completes immediately.
                            r_hi    <= operand_a;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_upper   <= '0;
                            r_lower   <= operand_a;
                            r_operand <= operand_b;
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_dbz     <= 1'b0;
                            r_state   <= DIV;
                        end
                    end
                end
                MUL, DIV: begin
                    r_upper <= w_next_upper;
                    r_lower <= w_next_lower;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        // Final iteration result goes straight to HI/LO.
                        r_hi    <= w_next_upper;
                        r_lo    <= w_next_lower;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for the mult/div sequencer: a fixed vector table, hand-written
// corner sequences and randomized operations against an arithmetic model.
module tb_hilo_muldiv_ctrl;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Present a start for one clock; returns in the cycle after acceptance.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(negedge clock);
        start = 1'b1; alu_ctrl = op; operand_a = a; operand_b = b;
        @(negedge clock);
        start = 1'b0; alu_ctrl = 4'b0000;
    endtask

    // lat = cycle index (1 = first cycle after accept) where done is seen.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Arithmetic reference taken straight from the operation definitions.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output logic [W-1:0] eh,
                         output logic [W-1:0] el, output logic edbz,
                         output int elat);
        logic [63:0] p;
        if (op == 4'b1111) begin
            p = 64'(a) * 64'(b);
            eh = p[63:32]; el = p[31:0]; edbz = 1'b0; elat = W + 1;
        end else if (b == 0) begin
            eh = a; el = '1; edbz = 1'b1; elat = 1;
        end else begin
            eh = a % b; el = a / b; edbz = 1'b0; elat = W + 1;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edbz, input int elat);
        int lat, bc;
        issue(op, a, b);
        wait_done(lat, bc);
        check({name, ".latency"}, 64'(lat), 64'(elat));
        check({name, ".busy_cycles"}, 64'(bc), (elat == 1) ? 64'd0 : 64'(W));
        check({name, ".hi"}, 64'(hi), 64'(eh));
        check({name, ".lo"}, 64'(lo), 64'(el));
        check({name, ".dbz"}, 64'(div_by_zero), 64'(edbz));
        @(negedge clock);
        check({name, ".done_pulse"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bc, seen;
        logic [3:0]   rop;
        logic [W-1:0] ra, rb, eh, el;
        logic         edbz;
        int           elat;

        vecs[0] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{4'b0011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        vecs[2] = '{4'b0011, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{4'b1111, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0};
        vecs[4] = '{4'b0011, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[5] = '{4'b0011, 32'd5, 32'd100000, 32'd5, 32'd0, 1'b0};
        vecs[6] = '{4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0};
        vecs[8] = '{4'b1111, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0};
        vecs[9] = '{4'b1111, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0};

        reset = 1'b1; start = 1'b0; alu_ctrl = 4'b0000;
        operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.busy_done_dbz", 64'({busy, done, div_by_zero}), 64'd0);

        // Unrecognised ALU control is ignored.
        issue(4'b0010, 32'd9, 32'd9);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (busy || done) seen++;
            @(negedge clock);
        end
        check("bad_ctrl.no_activity", 64'(seen), 64'd0);
        check("bad_ctrl.lo", 64'(lo), 64'd0);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz,
                   (vecs[i].op == 4'b0011 && vecs[i].b == 0) ? 1 : W + 1);
        end

        // Sticky divide-by-zero survives idle cycles.
        issue(4'b0011, 32'd1, 32'd0);
        wait_done(lat, bc);
        repeat (4) @(negedge clock);
        check("dbz_sticky", 64'(div_by_zero), 64'd1);

        // Start pulsed while busy is ignored.
        issue(4'b0011, 32'd100, 32'd7);
        repeat (4) @(negedge clock);
        start = 1'b1; alu_ctrl = 4'b1111; operand_a = 32'd3; operand_b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, bc);
        check("busy_start.latency", 64'(lat + 5), 64'(W + 1));
        check("busy_start.hi", 64'(hi), 64'd2);
        check("busy_start.lo", 64'(lo), 64'd14);
        repeat (40) @(negedge clock);
        check("busy_start.no_queue", 64'({busy, lo}), 64'd14);

        // Reset in the middle of a multiply.
        issue(4'b1111, 32'd6, 32'd7);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_reset.hilo", {hi, lo}, 64'd0);
        check("mid_reset.busy_done", 64'({busy, done}), 64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) seen++;
            @(negedge clock);
        end
        check("mid_reset.no_done", 64'(seen), 64'd0);
        run_op("after_reset", 4'b1111, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, W + 1);

        // Operands change after acceptance.
        issue(4'b1111, 32'd5, 32'd9);
        repeat (2) @(negedge clock);
        operand_a = 32'd0; operand_b = 32'd0;
        wait_done(lat, bc);
        check("operand_change.lo", 64'(lo), 64'd45);
        check("operand_change.hi", 64'(hi), 64'd0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'b0011;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            model(rop, ra, rb, eh, el, edbz, elat);
            run_op($sformatf("rand%0d", i), rop, ra, rb, eh, el, edbz, elat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
